// File: rtl/aes_control_param.sv
// Round-sequencing controller for a ring-pipelined AES datapath.
// A token ring with CPR positions tracks in-flight blocks; position 0 is the sole inject/exit point.
module aes_control_param #(
  parameter int unsigned CPR   = 4,
  parameter int unsigned SLOTS = 3,
  parameter int unsigned NR    = 10
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           kill,
  input  logic                           in_en,
  output logic                           start,
  output logic                           en_mixcol,
  output logic                           key_req,
  output logic [3:0]                     key_sel,
  output logic                           out_en,
  output logic                           idle,
  output logic [$clog2(SLOTS+1)-1:0]     inflight,
  output logic                           in_en_collision_irq_pulse
);

  localparam int unsigned CW = $clog2(SLOTS + 1);

  generate
    if (CPR < 1 || CPR > 8 || SLOTS < 1 || SLOTS > CPR ||
        !(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_params
      $error("aes_control_param: illegal parameter set");
    end
  endgenerate

  logic [CPR-1:0] valid_q, valid_d;
  logic [3:0]     rnd_q [CPR];
  logic [3:0]     rnd_d [CPR];
  logic [CW-1:0]  inflight_q, inflight_d;
  logic           start_q, start_d;
  logic           en_mixcol_q, en_mixcol_d;
  logic           key_req_q, key_req_d;
  logic [3:0]     key_sel_q, key_sel_d;
  logic           out_en_q, out_en_d;
  logic           idle_q, idle_d;
  logic           irq_q, irq_d;

  logic           arr_valid, arr_exit, arr_cont, do_inject;
  logic [3:0]     arr_rnd, nxt_rnd;

  always_comb begin
    // The token in the last position is the one arriving at position 0 on this edge.
    arr_valid = valid_q[CPR-1];
    arr_rnd   = rnd_q[CPR-1];
    nxt_rnd   = arr_rnd + 4'd1;
    arr_exit  = arr_valid && (arr_rnd == 4'(NR));
    arr_cont  = arr_valid && (arr_rnd < 4'(NR));
    do_inject = in_en && !arr_cont && ((inflight_q < CW'(SLOTS)) || arr_exit);

    valid_d     = '0;
    for (int unsigned i = 0; i < CPR; i++) rnd_d[i] = '0;
    start_d     = 1'b0;
    en_mixcol_d = 1'b0;
    key_req_d   = 1'b0;
    key_sel_d   = key_sel_q;
    out_en_d    = 1'b0;
    irq_d       = in_en && !do_inject;
    inflight_d  = inflight_q;

    for (int unsigned i = 1; i < CPR; i++) begin
      valid_d[i] = valid_q[i-1];
      rnd_d[i]   = rnd_q[i-1];
    end

    if (arr_exit) out_en_d = 1'b1;

    if (arr_cont) begin
      valid_d[0]  = 1'b1;
      rnd_d[0]    = nxt_rnd;
      key_req_d   = 1'b1;
      key_sel_d   = nxt_rnd;
      en_mixcol_d = nxt_rnd < 4'(NR);
    end

    if (do_inject) begin
      valid_d[0]  = 1'b1;
      rnd_d[0]    = 4'd1;
      start_d     = 1'b1;
      key_req_d   = 1'b1;
      key_sel_d   = 4'd1;
      en_mixcol_d = 1'b1;
    end

    if (do_inject && !arr_exit)      inflight_d = inflight_q + CW'(1);
    else if (!do_inject && arr_exit) inflight_d = inflight_q - CW'(1);

    if (kill) begin
      valid_d = '0;
      for (int unsigned i = 0; i < CPR; i++) rnd_d[i] = '0;
      inflight_d  = '0;
      start_d     = 1'b0;
      en_mixcol_d = 1'b0;
      key_req_d   = 1'b0;
      key_sel_d   = key_sel_q;
      out_en_d    = 1'b0;
      irq_d       = 1'b0;
    end

    idle_d = (inflight_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= '0;
      for (int unsigned i = 0; i < CPR; i++) rnd_q[i] <= '0;
      inflight_q  <= '0;
      start_q     <= 1'b0;
      en_mixcol_q <= 1'b0;
      key_req_q   <= 1'b0;
      key_sel_q   <= '0;
      out_en_q    <= 1'b0;
      idle_q      <= 1'b1;
      irq_q       <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      for (int unsigned i = 0; i < CPR; i++) rnd_q[i] <= rnd_d[i];
      inflight_q  <= inflight_d;
      start_q     <= start_d;
      en_mixcol_q <= en_mixcol_d;
      key_req_q   <= key_req_d;
      key_sel_q   <= key_sel_d;
      out_en_q    <= out_en_d;
      idle_q      <= idle_d;
      irq_q       <= irq_d;
    end
  end

  assign start                     = start_q;
  assign en_mixcol                 = en_mixcol_q;
  assign key_req                   = key_req_q;
  assign key_sel                   = key_sel_q;
  assign out_en                    = out_en_q;
  assign idle                      = idle_q;
  assign inflight                  = inflight_q;
  assign in_en_collision_irq_pulse = irq_q;

endmodule

// File: tb/tb_aes_control_param.sv
// Directed bench: default configuration (CPR=4, SLOTS=3, NR=10) plus a CPR=1/SLOTS=1/NR=14 instance.
module tb_aes_control_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       kill1 = 1'b0, in_en1 = 1'b0;
  logic       kill2 = 1'b0, in_en2 = 1'b0;

  logic       start1, mix1, kreq1, out1, idle1, irq1;
  logic [3:0] ksel1;
  logic [1:0] inf1;
  logic       start2, mix2, kreq2, out2, idle2, irq2;
  logic [3:0] ksel2;
  logic [0:0] inf2;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  aes_control_param #(.CPR(4), .SLOTS(3), .NR(10)) dut1 (
    .clk(clk), .rst_n(rst_n), .kill(kill1), .in_en(in_en1),
    .start(start1), .en_mixcol(mix1), .key_req(kreq1), .key_sel(ksel1),
    .out_en(out1), .idle(idle1), .inflight(inf1), .in_en_collision_irq_pulse(irq1)
  );

  aes_control_param #(.CPR(1), .SLOTS(1), .NR(14)) dut2 (
    .clk(clk), .rst_n(rst_n), .kill(kill2), .in_en(in_en2),
    .start(start2), .en_mixcol(mix2), .key_req(kreq2), .key_sel(ksel2),
    .out_en(out2), .idle(idle2), .inflight(inf2), .in_en_collision_irq_pulse(irq2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    total++; if ({start1, mix1, kreq1, out1, irq1} !== 5'b0) $display("FAIL reset.pulses1 got %b exp 00000", {start1, mix1, kreq1, out1, irq1}); else passed++;
    total++; if (ksel1 !== 4'd0) $display("FAIL reset.key_sel1 got %0d exp 0", ksel1); else passed++;
    total++; if (idle1 !== 1'b1) $display("FAIL reset.idle1 got %b exp 1", idle1); else passed++;
    total++; if (inf1 !== 2'd0) $display("FAIL reset.inflight1 got %0d exp 0", inf1); else passed++;
    total++; if ({start2, mix2, kreq2, out2, irq2, idle2, inf2} !== 7'b0000010) $display("FAIL reset.dut2 got %b exp 0000010", {start2, mix2, kreq2, out2, irq2, idle2, inf2}); else passed++;
    rst_n = 1'b1;
    step(); step();
  endtask

  task automatic test_single();
    logic       e_kreq;
    logic [3:0] e_ksel;
    in_en1 = 1'b1;
    for (int c = 1; c <= 42; c++) begin
      step();
      in_en1 = 1'b0;
      e_kreq = (c <= 37) && ((c - 1) % 4 == 0);
      e_ksel = (c >= 37) ? 4'd10 : 4'(1 + (c - 1) / 4);
      total++; if (start1 !== (c == 1)) $display("FAIL single.start c=%0d got %b exp %b", c, start1, c == 1); else passed++;
      total++; if (kreq1 !== e_kreq) $display("FAIL single.key_req c=%0d got %b exp %b", c, kreq1, e_kreq); else passed++;
      total++; if (mix1 !== (e_kreq && c != 37)) $display("FAIL single.en_mixcol c=%0d got %b exp %b", c, mix1, e_kreq && c != 37); else passed++;
      total++; if (ksel1 !== e_ksel) $display("FAIL single.key_sel c=%0d got %0d exp %0d", c, ksel1, e_ksel); else passed++;
      total++; if (out1 !== (c == 41)) $display("FAIL single.out_en c=%0d got %b exp %b", c, out1, c == 41); else passed++;
      total++; if (inf1 !== ((c <= 40) ? 2'd1 : 2'd0)) $display("FAIL single.inflight c=%0d got %0d exp %0d", c, inf1, (c <= 40) ? 1 : 0); else passed++;
      total++; if (idle1 !== (c > 40)) $display("FAIL single.idle c=%0d got %b exp %b", c, idle1, c > 40); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    in_en1 = 1'b1;
    for (int c = 1; c <= 82; c++) begin
      step();
      in_en1 = (c == 40);
      total++; if (start1 !== (c == 1 || c == 41)) $display("FAIL b2b.start c=%0d got %b exp %b", c, start1, c == 1 || c == 41); else passed++;
      total++; if (out1 !== (c == 41 || c == 81)) $display("FAIL b2b.out_en c=%0d got %b exp %b", c, out1, c == 41 || c == 81); else passed++;
      total++; if (inf1 !== ((c <= 80) ? 2'd1 : 2'd0)) $display("FAIL b2b.inflight c=%0d got %0d exp %0d", c, inf1, (c <= 80) ? 1 : 0); else passed++;
      if (c == 41) begin
        total++; if ({kreq1, mix1, ksel1} !== {1'b1, 1'b1, 4'd1}) $display("FAIL b2b.key41 got %b/%b/%0d exp 1/1/1", kreq1, mix1, ksel1); else passed++;
      end
    end
  endtask

  task automatic test_saturation();
    logic [1:0] e_inf;
    in_en1 = 1'b1;
    for (int c = 1; c <= 44; c++) begin
      step();
      in_en1 = (c <= 3);
      e_inf = (c <= 3) ? 2'(c) : (c <= 40) ? 2'd3 : (c <= 43) ? 2'(43 - c) : 2'd0;
      total++; if (start1 !== (c <= 3)) $display("FAIL sat.start c=%0d got %b exp %b", c, start1, c <= 3); else passed++;
      total++; if (irq1 !== (c == 4)) $display("FAIL sat.irq c=%0d got %b exp %b", c, irq1, c == 4); else passed++;
      total++; if (out1 !== (c >= 41 && c <= 43)) $display("FAIL sat.out_en c=%0d got %b exp %b", c, out1, c >= 41 && c <= 43); else passed++;
      total++; if (inf1 !== e_inf) $display("FAIL sat.inflight c=%0d got %0d exp %0d", c, inf1, e_inf); else passed++;
    end
  endtask

  task automatic test_collision();
    logic [1:0] e_inf;
    in_en1 = 1'b1;
    for (int c = 1; c <= 47; c++) begin
      step();
      in_en1 = (c == 4 || c == 5);
      e_inf = (c <= 5) ? 2'd1 : (c <= 40) ? 2'd2 : (c <= 45) ? 2'd1 : 2'd0;
      total++; if (irq1 !== (c == 5)) $display("FAIL coll.irq c=%0d got %b exp %b", c, irq1, c == 5); else passed++;
      total++; if (start1 !== (c == 1 || c == 6)) $display("FAIL coll.start c=%0d got %b exp %b", c, start1, c == 1 || c == 6); else passed++;
      total++; if (out1 !== (c == 41 || c == 46)) $display("FAIL coll.out_en c=%0d got %b exp %b", c, out1, c == 41 || c == 46); else passed++;
      total++; if (inf1 !== e_inf) $display("FAIL coll.inflight c=%0d got %0d exp %0d", c, inf1, e_inf); else passed++;
      if (c == 5) begin
        total++; if ({kreq1, ksel1} !== {1'b1, 4'd2}) $display("FAIL coll.key5 got %b/%0d exp 1/2", kreq1, ksel1); else passed++;
      end
    end
  endtask

  task automatic test_kill();
    in_en1 = 1'b1;
    for (int c = 1; c <= 63; c++) begin
      step();
      in_en1 = (c == 1 || c == 20 || c == 21);
      kill1  = (c == 20);
      total++; if (out1 !== (c == 62)) $display("FAIL kill.out_en c=%0d got %b exp %b", c, out1, c == 62); else passed++;
      total++; if (start1 !== (c == 1 || c == 2 || c == 22)) $display("FAIL kill.start c=%0d got %b exp %b", c, start1, c == 1 || c == 2 || c == 22); else passed++;
      if (c == 20) begin
        total++; if (inf1 !== 2'd2) $display("FAIL kill.inflight20 got %0d exp 2", inf1); else passed++;
      end
      if (c == 21) begin
        total++; if ({inf1, idle1} !== {2'd0, 1'b1}) $display("FAIL kill.cleared got inflight=%0d idle=%b exp 0/1", inf1, idle1); else passed++;
        total++; if ({kreq1, irq1, mix1} !== 3'b000) $display("FAIL kill.suppress got %b exp 000", {kreq1, irq1, mix1}); else passed++;
      end
    end
  endtask

  task automatic test_nr14();
    logic [3:0] e_ksel;
    in_en2 = 1'b1;
    for (int c = 1; c <= 43; c++) begin
      step();
      e_ksel = 4'((c - 1) % 14 + 1);
      total++; if (start2 !== ((c - 1) % 14 == 0)) $display("FAIL nr14.start c=%0d got %b exp %b", c, start2, (c - 1) % 14 == 0); else passed++;
      total++; if (out2 !== (c >= 15 && (c - 1) % 14 == 0)) $display("FAIL nr14.out_en c=%0d got %b exp %b", c, out2, c >= 15 && (c - 1) % 14 == 0); else passed++;
      total++; if (irq2 !== (c >= 2 && (c - 1) % 14 != 0)) $display("FAIL nr14.irq c=%0d got %b exp %b", c, irq2, c >= 2 && (c - 1) % 14 != 0); else passed++;
      total++; if (ksel2 !== e_ksel) $display("FAIL nr14.key_sel c=%0d got %0d exp %0d", c, ksel2, e_ksel); else passed++;
      total++; if (mix2 !== (e_ksel != 4'd14)) $display("FAIL nr14.en_mixcol c=%0d got %b exp %b", c, mix2, e_ksel != 4'd14); else passed++;
      total++; if ({kreq2, inf2} !== 2'b11) $display("FAIL nr14.kreq_inflight c=%0d got %b exp 11", c, {kreq2, inf2}); else passed++;
    end
    in_en2 = 1'b0;
    for (int c = 44; c <= 58; c++) step();
    total++; if ({idle2, inf2} !== 2'b10) $display("FAIL nr14.drained got %b exp 10", {idle2, inf2}); else passed++;
  endtask

  task automatic test_reset_mid();
    in_en1 = 1'b1;
    for (int c = 1; c <= 62; c++) begin
      step();
      in_en1 = (c == 20);
      if (c == 15) begin
        rst_n = 1'b0;
        #1;
        total++; if ({start1, mix1, kreq1, out1, irq1} !== 5'b0) $display("FAIL rstmid.pulses got %b exp 00000", {start1, mix1, kreq1, out1, irq1}); else passed++;
        total++; if ({ksel1, inf1, idle1} !== {4'd0, 2'd0, 1'b1}) $display("FAIL rstmid.state got ksel=%0d inflight=%0d idle=%b exp 0/0/1", ksel1, inf1, idle1); else passed++;
      end
      if (c == 17) rst_n = 1'b1;
      total++; if (out1 !== (c == 61)) $display("FAIL rstmid.out_en c=%0d got %b exp %b", c, out1, c == 61); else passed++;
      if (c == 21) begin
        total++; if (start1 !== 1'b1) $display("FAIL rstmid.resume_start got %b exp 1", start1); else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_saturation();
    test_collision();
    test_kill();
    test_nr14();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
